// File: rtl/hazard_stall_ctrl.sv
// Purpose: load-use / MULT-DIV occupancy / taken-branch hazard sequencer for the 5-stage core.
// Latency: stall, bubble and flush are combinational in the hazard cycle; MULT/DIV busy for N cycles after accept.
// Backpressure: holds PC and IF/ID (inserting an ID/EX bubble) while a load-use or MULT/DIV hazard is present.
module hazard_stall_ctrl #(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32,
  parameter int CNT_W       = 6,
  parameter int PERF_W      = 16
) (
  input  logic              ip_clk,
  input  logic              ip_rst_n,
  input  logic              ip_ID_EX_MemRead,
  input  logic [4:0]        ip_ID_EX_dest,
  input  logic [4:0]        ip_IF_ID_rs,
  input  logic [4:0]        ip_IF_ID_rt,
  input  logic              ip_IF_ID_uses_rt,
  input  logic              ip_IF_ID_md_start,
  input  logic              ip_IF_ID_md_is_div,
  input  logic              ip_IF_ID_reads_hilo,
  input  logic              ip_EX_branch_taken,
  output logic              op_PC_write,
  output logic              op_IF_ID_write,
  output logic              op_ID_EX_bubble,
  output logic              op_IF_ID_flush,
  output logic              op_md_busy,
  output logic              op_md_done,
  output logic [PERF_W-1:0] op_stall_cycles
);

  typedef enum logic {
    IDLE    = 1'b0,
    MD_BUSY = 1'b1
  } state_t;

  // Counter reload values: the counter runs N-1 down to 0, so done lands on the Nth busy cycle.
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PERF_W-1:0]  perf_q;

  logic lu_hit;
  logic md_hit;
  logic flush;
  logic stall;
  logic accept;

  // Raw hazard terms and their priority resolution (flush > load-use > MULT/DIV).
  always_comb begin
    lu_hit = 1'b0;
    if (ip_ID_EX_MemRead && (ip_ID_EX_dest != 5'd0)) begin
      lu_hit = (ip_ID_EX_dest == ip_IF_ID_rs) ||
               (ip_IF_ID_uses_rt && (ip_ID_EX_dest == ip_IF_ID_rt));
    end
    md_hit = (state_q == MD_BUSY) && (ip_IF_ID_md_start || ip_IF_ID_reads_hilo);
    flush  = ip_EX_branch_taken;
    stall  = !ip_EX_branch_taken && (lu_hit || md_hit);
    // A flushed or load-stalled MULT/DIV is not taken; it re-presents later.
    accept = (state_q == IDLE) && ip_IF_ID_md_start && !ip_EX_branch_taken && !lu_hit;
  end

  // Pipeline control outputs; held at their reset values while reset is asserted.
  always_comb begin
    op_PC_write     = 1'b1;
    op_IF_ID_write  = 1'b1;
    op_ID_EX_bubble = 1'b0;
    op_IF_ID_flush  = 1'b0;
    op_md_busy      = 1'b0;
    op_md_done      = 1'b0;
    if (ip_rst_n) begin
      op_PC_write     = !stall;
      op_IF_ID_write  = !stall;
      op_ID_EX_bubble = flush || stall;
      op_IF_ID_flush  = flush;
      op_md_busy      = (state_q == MD_BUSY);
      op_md_done      = (state_q == MD_BUSY) && (cnt_q == '0);
    end
  end

  // MULT/DIV occupancy FSM next-state: an in-flight operation ignores branch flushes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = MD_BUSY;
          cnt_d   = ip_IF_ID_md_is_div ? DIV_LOAD : MULT_LOAD;
        end
      end
      MD_BUSY: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM state and down-counter registers; reset abandons any operation in flight.
  always_ff @(posedge ip_clk or negedge ip_rst_n) begin
    if (!ip_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Saturating count of cycles in which the PC was held.
  always_ff @(posedge ip_clk or negedge ip_rst_n) begin
    if (!ip_rst_n) begin
      perf_q <= '0;
    end else if (stall && (perf_q != '1)) begin
      perf_q <= perf_q + PERF_W'(1);
    end
  end

  assign op_stall_cycles = perf_q;

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline hazard and stall sequencer for the 5-stage MIPS core. It works alongside the EX-stage forwarding unit.
- It covers the hazards that forwarding cannot resolve:
  - load-use on a decode-stage operand;
  - issue and occupancy of the multi-cycle MULT/DIV unit, including HI/LO readers;
  - taken-branch flush of IF/ID.
- It drives PC/IF-ID write enables, the ID/EX bubble and the IF/ID flush, and keeps a saturating stall-cycle performance counter.

Parameters:
MULT_CYCLES, 4, MULT/MULTU execution latency in cycles (legal range 1..2^CNT_W)
DIV_CYCLES, 32, DIV/DIVU execution latency in cycles (legal range 1..2^CNT_W)
CNT_W, 6, width of the MULT/DIV cycle down-counter
PERF_W, 16, width of the stall-cycle counter

Ports:
ip_clk  in  1  core clock, all state on the rising edge
ip_rst_n  in  1  asynchronous, active-low reset
ip_ID_EX_MemRead  in  1  instruction in EX is a load
ip_ID_EX_dest  in  5  destination register of the instruction in EX
ip_IF_ID_rs  in  5  rs of the instruction in decode
ip_IF_ID_rt  in  5  rt of the instruction in decode
ip_IF_ID_uses_rt  in  1  decode instruction reads rt as a source
ip_IF_ID_md_start  in  1  decode instruction is MULT/MULTU/DIV/DIVU
ip_IF_ID_md_is_div  in  1  qualifies md_start: 1=DIV, 0=MULT
ip_IF_ID_reads_hilo  in  1  decode instruction is MFHI/MFLO
ip_EX_branch_taken  in  1  branch resolved taken in EX this cycle
op_PC_write  out  1  PC update enable
op_IF_ID_write  out  1  IF/ID register load enable
op_ID_EX_bubble  out  1  zero the control fields entering ID/EX
op_IF_ID_flush  out  1  clear IF/ID to a NOP
op_md_busy  out  1  MULT/DIV unit occupied (state MD_BUSY)
op_md_done  out  1  final MULT/DIV cycle; HI/LO are written this cycle
op_stall_cycles  out  PERF_W  saturating count of stall cycles

Behaviour:
- Reset (ip_rst_n=0, asynchronous):
  - state=IDLE, counter=0, op_stall_cycles=0;
  - op_PC_write=1, op_IF_ID_write=1;
  - op_ID_EX_bubble=0, op_IF_ID_flush=0, op_md_busy=0, op_md_done=0.
  - Asserting reset mid-MULT/DIV abandons the operation; no done pulse is produced.
- State machine: IDLE and MD_BUSY.
  - Counter is CNT_W bits.
  - op_md_busy = (state==MD_BUSY).
  - op_md_done = (state==MD_BUSY && counter==0).
- Hazard terms, evaluated combinationally in the same cycle:
  - lu = ID_EX_MemRead && ID_EX_dest!=0 && (dest==rs || (uses_rt && dest==rt)).
  - md = (state==MD_BUSY) && (IF_ID_md_start || IF_ID_reads_hilo).
- Priority:
  - Flush (branch_taken) beats lu, which beats md. flush/lu/md below are these terms after masking by priority, so at most one is active per cycle.
  - Flush: op_IF_ID_flush=1, op_ID_EX_bubble=1, op_PC_write=1, op_IF_ID_write=1. Any lu/md stall that cycle is cancelled.
  - Stall (lu or md, no flush): op_PC_write=0, op_IF_ID_write=0, op_ID_EX_bubble=1, op_IF_ID_flush=0.
  - Otherwise all enables are 1 and bubble/flush are 0.
- MULT/DIV issue (accept):
  - Condition: state==IDLE && md_start && !branch_taken && !lu.
  - On accept the counter loads (is_div ? DIV_CYCLES : MULT_CYCLES)-1 and the next state is MD_BUSY.
  - A flushed or load-stalled md_start is not accepted; it is re-evaluated when it re-presents.
- MD_BUSY:
  - The counter decrements each cycle.
  - When counter==0, op_md_done is high for exactly that cycle and the next state is IDLE.
  - A MULT/DIV already in flight is NOT aborted by a branch flush.
- Issue is accepted from IDLE only. A MULT/DIV or MFHI/MFLO in decode during the done cycle still stalls that cycle and proceeds the next cycle.
- Latency:
  - Accept at edge t; MD_BUSY for cycles t+1..t+N; op_md_done at t+N.
  - A dependent MFHI presented at t+1 leaves decode at t+N+1 (stall of N cycles).
- Perf counter:
  - Increments by 1 on each cycle where op_PC_write==0.
  - Saturates at 2^PERF_W-1 and never wraps.
- Register $0 never causes a load-use stall. uses_rt=0 masks any rt match.

Test Plan:
- Load-use: EX lw with dest=5, decode rs=5 -> exactly 1 cycle with PC_write=0, IF_ID_write=0, bubble=1, then all clear; stall_cycles=1. Repeat with dest=0 or rt=5 and uses_rt=0 -> no stall.
- MULT issue with MULT_CYCLES=4, then MFHI in decode the next cycle -> md_busy high 4 cycles, md_done high in the 4th only, MFHI stalled 4 cycles, stall_cycles=4.
- DIV back-to-back: second DIV in decode while busy -> stalled 32 cycles. It is accepted the cycle after done, and a second done follows 32 cycles later.
- Simultaneous branch_taken with a load-use hit and with md_start in IDLE -> flush=1, bubble=1, PC_write=1, no stall, no MULT/DIV accepted (md_busy stays 0).
- Branch flush during MD_BUSY -> counter keeps running and md_done still fires on schedule. Drive ip_rst_n low mid-DIV -> outputs return immediately to reset values, with no done pulse.
- Saturation with PERF_W=4: force 20 stall cycles -> op_stall_cycles holds at 15.
